// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for the EX stage: one quotient bit per cycle,
// result {remainder, quotient} feeds HI/LO, and stall_div holds the front end while busy.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_valid,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    input  logic                 hold,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_div
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        ON   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_neg_a;
    logic                  r_neg_b;
    logic [WIDTH-1:0]      r_divisor;
    logic [2*WIDTH:0]      r_work;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_result;

    logic signed [WIDTH-1:0] w_dvd_s;
    logic signed [WIDTH-1:0] w_dvs_s;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic                  w_accept;
    logic                  w_b_zero;
    logic                  w_last;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [2*WIDTH:0]      w_shift;
    logic [WIDTH+1:0]      w_sub;
    logic [2*WIDTH:0]      w_work_nxt;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? -mag : mag;
    endfunction

    assign w_dvd_s  = opdata1;
    assign w_dvs_s  = opdata2;
    assign w_neg_a  = signed_div && (w_dvd_s < 0);
    assign w_neg_b  = signed_div && (w_dvs_s < 0);
    assign w_abs_a  = apply_sign(opdata1, w_neg_a);
    assign w_abs_b  = apply_sign(opdata2, w_neg_b);
    assign w_b_zero = (opdata2 == '0);
    assign w_accept = (r_state == IDLE) && div_valid && !annul;
    assign w_last   = (r_cnt == LAST_STEP);

    // Restoring step: the upper WIDTH+1 bits hold the partial remainder, a borrow means "keep"
    assign w_shift    = r_work << 1;
    assign w_sub      = {1'b0, w_shift[2*WIDTH:WIDTH]} - {2'b00, r_divisor};
    assign w_work_nxt = w_sub[WIDTH+1] ? w_shift
                                       : {w_sub[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_b_zero ? ZERO : ON;
            ON: begin
                if (annul)       w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            ZERO: w_state_nxt = annul ? IDLE : DONE;
            DONE: if (annul || !hold) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == ON && !annul) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Divide-by-zero restores the dividend as given by undoing the magnitude fold
            if (r_state == ON && !annul && w_last) begin
                r_result <= {apply_sign(w_work_nxt[2*WIDTH-1:WIDTH], r_neg_a),
                             apply_sign(w_work_nxt[WIDTH-1:0], r_neg_a ^ r_neg_b)};
            end else if (r_state == ZERO && !annul) begin
                r_result <= {apply_sign(r_work[WIDTH-1:0], r_neg_a), {WIDTH{1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_divisor <= w_abs_b;
            r_work    <= {{(WIDTH+1){1'b0}}, w_abs_a};
        end else if (r_state == ON) begin
            r_work    <= w_work_nxt;
        end
    end

    assign result    = r_result;
    assign ready     = (r_state == DONE);
    assign stall_div = w_accept || (r_state == ON) || (r_state == ZERO);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences
// (annul, reset, hold, back-to-back) and randomized operands against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        hold;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .hold       (hold),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request in the current cycle and returns in the first ready cycle
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [63:0] res, output int lat,
                                  output logic stall_ok);
        logic seen;
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        div_valid  = 1'b1;
        stall_ok   = 1'b1;
        seen       = 1'b0;
        res        = '0;
        #1;
        if (stall_div !== 1'b1) stall_ok = 1'b0;
        @(posedge clk); #1;
        div_valid  = 1'b0;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~s;
        lat = 1;
        while (!seen && lat <= 40) begin
            #1;
            if (ready === 1'b1) begin
                seen = 1'b1;
                if (stall_div !== 1'b0) stall_ok = 1'b0;
                res = result;
            end else begin
                if (stall_div !== 1'b1) stall_ok = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic finish_idle(input string name);
        @(posedge clk); #2;
        chk({name, " ready drops"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        logic [63:0] res, exp, prior;
        logic        stall_ok, all_stall_ok, never_ready;
        int          lat;
        logic [31:0] a, b;
        logic        s;

        tbl[0] = '{32'd100,        32'd7,          1'b0, {32'd2,          32'd14},         33};
        tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFD},  33};
        tbl[2] = '{32'hFFFF_FFF9,  32'd2,          1'b0, {32'd1,          32'h7FFF_FFFC},  33};
        tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0,          32'h8000_0000},  33};
        tbl[4] = '{32'd5,          32'd0,          1'b0, {32'd5,          32'hFFFF_FFFF},   2};
        tbl[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1,          32'hFFFF_FFFD},  33};
        tbl[6] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF,  32'd3},          33};
        tbl[7] = '{32'd0,          32'd5,          1'b1, {32'd0,          32'd0},          33};
        tbl[8] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0,          32'hFFFF_FFFF},  33};
        tbl[9] = '{32'hFFFF_FFFB,  32'd0,          1'b1, {32'hFFFF_FFFB,  32'hFFFF_FFFF},   2};

        rst = 1'b1; div_valid = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
        annul = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset ready", {63'd0, ready}, 64'd0);
        chk("reset stall", {63'd0, stall_div}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            start_and_wait(tbl[i].a, tbl[i].b, tbl[i].s, res, lat, stall_ok);
            chk($sformatf("vec%0d result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d stall", i), {63'd0, stall_ok}, 64'd1);
            finish_idle($sformatf("vec%0d", i));
        end
        prior = tbl[9].exp;

        // Annul mid-divide: no ready, result keeps the previous value
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        #1;
        chk("annul stall", {63'd0, stall_div}, 64'd0);
        chk("annul ready", {63'd0, ready}, 64'd0);
        never_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (ready !== 1'b0) never_ready = 1'b0;
        end
        chk("annul never ready", {63'd0, never_ready}, 64'd1);
        chk("annul result kept", result, prior);

        // Reset mid-divide clears the result
        opdata1 = 32'd77777; opdata2 = 32'd13; signed_div = 1'b0; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst result", result, 64'd0);
        chk("midrst ready", {63'd0, ready}, 64'd0);
        never_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (ready !== 1'b0) never_ready = 1'b0;
        end
        chk("midrst never ready", {63'd0, never_ready}, 64'd1);

        // Hold in DONE keeps ready and result for three extra cycles, then back-to-back
        hold = 1'b1;
        exp  = ref_div(32'd12345, 32'd67, 1'b0);
        start_and_wait(32'd12345, 32'd67, 1'b0, res, lat, stall_ok);
        chk("hold result", res, exp);
        chk("hold latency", 64'(lat), 64'd33);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #2;
            chk($sformatf("hold%0d ready", k), {63'd0, ready}, 64'd1);
            chk($sformatf("hold%0d result", k), result, exp);
        end
        hold = 1'b0;
        finish_idle("hold release");
        start_and_wait(32'd9, 32'd3, 1'b0, res, lat, stall_ok);
        chk("b2b result", res, {32'd0, 32'd3});
        chk("b2b latency", 64'(lat), 64'd33);
        finish_idle("b2b");

        // Randomized operands against the arithmetic model
        all_stall_ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(0, 31);
                4:       b = -($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            s   = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s);
            start_and_wait(a, b, s, res, lat, stall_ok);
            if (!stall_ok) all_stall_ok = 1'b0;
            chk($sformatf("rand%0d %h/%h s%0d", i, a, b, s), res, exp);
            chk($sformatf("rand%0d latency", i), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
            @(posedge clk); #1;
        end
        chk("rand stall", {63'd0, all_stall_ok}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage; the responder to the controller's EX-stage divide signals (div_validE, signed_divE).
- Accepts a divide request and computes {remainder, quotient} with one restoring-division step per cycle.
- Holds the EX stage with stall_div until the result is ready.
- The result is written to HI (remainder) and LO (quotient) through the existing hi_we/lo_we path.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- div_valid  input  1  divide request from the EX-stage control (div_validE).
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1  input  WIDTH  dividend (rs); sampled at accept.
- opdata2  input  WIDTH  divisor (rt); sampled at accept.
- annul  input  1  cancel the request or the divide in flight (exception/flush).
- hold  input  1  EX held by another stall source; keeps DONE from retiring.
- result  output  2*WIDTH  {remainder, quotient}; [63:32]->HI, [31:0]->LO.
- ready  output  1  result valid this cycle.
- stall_div  output  1  request pipeline stall of PC/IF/ID/EX.

Behaviour:
- States: IDLE, ZERO, ON, DONE. Reset: state=IDLE, result=0, ready=0, stall_div=0, counter=0.
- rst has priority over everything. Reset mid-operation returns the block to IDLE, drops the partial result and raises no ready.
- IDLE:
  - div_valid=1 and annul=0: latch signed_div, sign(opdata1) and sign(opdata2). Latch operand magnitudes: two's-complement absolute value if signed_div=1, otherwise raw.
  - divisor==0 -> ZERO; otherwise -> ON with counter=0 and working register {33'b0, |dividend|}.
  - annul=1 or div_valid=0: stay IDLE.
- ON:
  - Each cycle: shift the working register left by 1.
  - Trial-subtract |divisor| from the upper 33 bits. If non-negative, store the difference and set LSB=1; otherwise keep the shifted value with LSB=0.
  - Counter increments. After step 32 (counter==31), go to DONE and load result.
- Sign fix on load into result:
  - Quotient is negated iff signed and sign(a)^sign(b).
  - Remainder is negated iff signed and sign(a).
- ZERO: one cycle, then DONE with quotient=all ones and remainder=opdata1 as latched.
- annul in ON or ZERO: next state IDLE, result unchanged, ready never asserted.
- DONE:
  - ready=1 and result is stable.
  - hold=1: stay in DONE; ready stays 1 and result is held.
  - hold=0: go to IDLE next cycle; ready=0 from then on. result holds its value until the next DONE load or rst.
  - annul in DONE: go to IDLE.
- Latency: accept in cycle T, ready=1 in cycle T+33 for a normal divide and T+2 for divide-by-zero.
- Back-to-back: a second request presented in the cycle after DONE is accepted from IDLE normally.
- stall_div (combinational) = (state==IDLE & div_valid & ~annul) | state==ON | state==ZERO. It is 0 in DONE, so EX advances in the ready cycle.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) needs no special path: it gives quotient 0x80000000, remainder 0.
- Inputs are sampled only at accept. Changes to opdata1, opdata2 or signed_div while in ON must not affect the result.

Test Plan:
- Unsigned 100/7, accept at T -> stall_div=1 from T to T+32; ready=1 at T+33; result={32'd2, 32'd14}; stall_div=0 at T+33.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Divide-by-zero 5/0 -> ready at T+2, quotient 0xFFFFFFFF, remainder 5.
- annul at T+10 of a 1000/3 divide -> IDLE at T+11, ready never rises, stall_div=0, result keeps its prior value. rst at T+5 of another divide -> result=0, ready=0.
- hold=1 for 3 cycles in DONE -> ready and result stable for 4 cycles. Then a back-to-back 9/3 request the cycle after IDLE -> result {0, 3} 33 cycles after that accept.
- Randomized signed and unsigned operands (500 pairs) compared against a reference model.
